// File: rtl/temp_uart_scheduler_pkg.sv
// Shared types and constants for the temperature report UART scheduler.
// Holds the FSM state encoding, ASCII characters and frame byte selection.
package temp_uart_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LATCH   = 3'd1,
    FMT     = 3'd2,
    ISSUE   = 3'd3,
    WAIT_HI = 3'd4,
    WAIT_LO = 3'd5
  } state_t;

  localparam logic [7:0] PLUS  = 8'h2B;
  localparam logic [7:0] MINUS = 8'h2D;
  localparam logic [7:0] DOT   = 8'h2E;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] ZERO  = 8'h30;

  localparam int FRAME_LEN = 8;

  // Byte 0 is the first character on the wire and sits in the top byte of the frame.
  function automatic logic [7:0] frame_byte(input logic [63:0] frame, input logic [2:0] idx);
    return frame[{~idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/temp_ascii_fmt.sv
// Converts an 11-bit magnitude (LSB = 1/16 degC) plus sign into the 8-byte "sDDD.F\r\n" frame.
// Decimal digits come from compare/subtract steps, so no divider is inferred.
module temp_ascii_fmt
  import temp_uart_scheduler_pkg::*;
(
  input  logic [10:0] t,
  input  logic        sign,
  output logic [63:0] frame
);

  logic [6:0] rem_s;
  logic [3:0] hund_s;
  logic [3:0] tens_s;
  logic [3:0] frac_s;
  logic [3:0] frac_lo_unused;
  logic       step_s;
  logic [7:0] sign_char_s;

  // Tenths digit: (t[3:0] * 10) >> 4, keeping only the integer part.
  assign {frac_s, frac_lo_unused} = {4'd0, t[3:0]} * 8'd10;

  // Integer part split into hundreds/tens/ones by repeated subtraction.
  always_comb begin
    hund_s      = (t[10:4] >= 7'd100) ? 4'd1 : 4'd0;
    rem_s       = (t[10:4] >= 7'd100) ? (t[10:4] - 7'd100) : t[10:4];
    tens_s      = 4'd0;
    step_s      = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step_s = (rem_s >= 7'd10);
      rem_s  = step_s ? (rem_s - 7'd10) : rem_s;
      tens_s = tens_s + {3'd0, step_s};
    end
    sign_char_s = (sign && (t != 11'd0)) ? MINUS : PLUS;
    frame       = {sign_char_s,
                   ZERO + {4'd0, hund_s},
                   ZERO + {4'd0, tens_s},
                   ZERO + {4'd0, rem_s[3:0]},
                   DOT,
                   ZERO + {4'd0, frac_s},
                   CR,
                   LF};
  end

endmodule

// File: rtl/temp_uart_scheduler.sv
// Periodically sends an ASCII temperature frame over a byte UART and, between frames,
// grants the UART to a single-byte secondary requester.
module temp_uart_scheduler
  import temp_uart_scheduler_pkg::*;
#(
  parameter int PERIOD_CLKS   = 12000000,
  parameter int BUSY_WAIT_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [15:0] temp_data,
  input  logic        temp_sign,
  input  logic        evt_valid,
  input  logic [7:0]  evt_byte,
  output logic        evt_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        frame_done,
  output logic        missed,
  output logic        tx_err
);

  localparam int CW = $clog2(PERIOD_CLKS);
  localparam int WW = (BUSY_WAIT_MAX > 1) ? $clog2(BUSY_WAIT_MAX) : 1;

  state_t        state_r, next_state_s;
  logic [CW-1:0] cnt_r;
  logic          tick_s;
  logic          pending_r, missed_r, tx_err_r;
  logic [10:0]   t_r;
  logic          sign_r;
  logic [63:0]   frame_r, fmt_frame_s;
  logic [2:0]    idx_r;
  logic          is_evt_r;
  logic [WW-1:0] wait_r;
  logic [7:0]    tx_data_r, next_data_s;
  logic          tx_start_r, evt_ready_r, frame_done_r;
  logic          take_report_s, take_evt_s, byte_done_s, err_now_s, last_byte_s;
  logic          unused_hi_s;

  assign unused_hi_s = ^temp_data[15:11];

  temp_ascii_fmt u_fmt (
    .t     (t_r),
    .sign  (sign_r),
    .frame (fmt_frame_s)
  );

  assign tick_s      = (cnt_r == CW'(PERIOD_CLKS - 1));
  assign last_byte_s = is_evt_r || (idx_r == 3'(FRAME_LEN - 1));

  // Next-state and arbitration; a tick in flight blocks evt so the report wins.
  always_comb begin
    next_state_s  = state_r;
    take_report_s = 1'b0;
    take_evt_s    = 1'b0;
    byte_done_s   = 1'b0;
    err_now_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (ena && !tx_busy && pending_r) begin
          next_state_s  = LATCH;
          take_report_s = 1'b1;
        end else if (ena && !tx_busy && evt_valid && !tick_s) begin
          next_state_s = ISSUE;
          take_evt_s   = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      LATCH:   next_state_s = FMT;
      FMT:     next_state_s = ISSUE;
      ISSUE:   next_state_s = WAIT_HI;
      WAIT_HI: begin
        if (tx_busy) begin
          next_state_s = WAIT_LO;
        end else if (wait_r == WW'(BUSY_WAIT_MAX - 1)) begin
          next_state_s = WAIT_LO;
          err_now_s    = 1'b1;
        end else begin
          next_state_s = WAIT_HI;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          byte_done_s  = 1'b1;
          next_state_s = last_byte_s ? IDLE : ISSUE;
        end else begin
          next_state_s = WAIT_LO;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Byte to present with the next tx_start.
  always_comb begin
    if (state_r == FMT) begin
      next_data_s = fmt_frame_s[63:56];
    end else if (take_evt_s) begin
      next_data_s = evt_byte;
    end else begin
      next_data_s = frame_byte(frame_r, idx_r + 3'd1);
    end
  end

  // Period counter, sticky flags, snapshot/frame registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      pending_r    <= 1'b0;
      missed_r     <= 1'b0;
      tx_err_r     <= 1'b0;
      t_r          <= 11'd0;
      sign_r       <= 1'b0;
      frame_r      <= 64'd0;
      idx_r        <= 3'd0;
      is_evt_r     <= 1'b0;
      wait_r       <= '0;
      tx_data_r    <= 8'd0;
      tx_start_r   <= 1'b0;
      evt_ready_r  <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      cnt_r        <= tick_s ? '0 : cnt_r + CW'(1);
      pending_r    <= tick_s | (pending_r & ~take_report_s);
      missed_r     <= missed_r | (tick_s & pending_r);
      tx_err_r     <= tx_err_r | err_now_s;
      if (state_r == LATCH) begin
        t_r    <= temp_data[10:0];
        sign_r <= temp_sign;
        idx_r  <= 3'd0;
      end
      if (state_r == FMT) frame_r <= fmt_frame_s;
      if (take_evt_s) is_evt_r <= 1'b1;
      else if (take_report_s) is_evt_r <= 1'b0;
      if (byte_done_s && !last_byte_s) idx_r <= idx_r + 3'd1;
      wait_r       <= (state_r == WAIT_HI) ? wait_r + WW'(1) : '0;
      if (next_state_s == ISSUE) tx_data_r <= next_data_s;
      tx_start_r   <= (next_state_s == ISSUE);
      evt_ready_r  <= take_evt_s;
      frame_done_r <= byte_done_s && !is_evt_r && (idx_r == 3'(FRAME_LEN - 1));
    end
  end

  assign evt_ready  = evt_ready_r;
  assign tx_data    = tx_data_r;
  assign tx_start   = tx_start_r;
  assign frame_done = frame_done_r;
  assign missed     = missed_r;
  assign tx_err     = tx_err_r;

endmodule
